// File: rtl/mem_arbiter_if.sv
// Bundle of every handshake/bus signal around mem_arbiter: icache port, dcache port, memory port.
// Latency: none (wires only).
// Backpressure: carries req ready/valid, write-data ready/valid; response beats have no backpressure.
// Ports (slave = arbiter view): ic_req_*/dc_req_* in, *_ready/*_resp_*/dc_wr_ack out,
// mem_req_* out, mem_req_ready/mem_req_data_ready/mem_resp_* in.
interface mem_arbiter_if #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128,
    parameter int TAG_W  = 4
);
    logic                  ic_req_valid;
    logic                  ic_req_ready;
    logic [ADDR_W-1:0]     ic_req_addr;
    logic                  ic_resp_valid;
    logic [DATA_W-1:0]     ic_resp_data;

    logic                  dc_req_valid;
    logic                  dc_req_ready;
    logic                  dc_req_rw;
    logic [ADDR_W-1:0]     dc_req_addr;
    logic [DATA_W-1:0]     dc_req_data;
    logic [DATA_W/8-1:0]   dc_req_mask;
    logic                  dc_resp_valid;
    logic [DATA_W-1:0]     dc_resp_data;
    logic                  dc_wr_ack;

    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic                  mem_req_rw;
    logic [ADDR_W-1:0]     mem_req_addr;
    logic [TAG_W-1:0]      mem_req_tag;
    logic                  mem_req_data_valid;
    logic                  mem_req_data_ready;
    logic [DATA_W-1:0]     mem_req_data_bits;
    logic [DATA_W/8-1:0]   mem_req_data_mask;
    logic                  mem_resp_valid;
    logic [TAG_W-1:0]      mem_resp_tag;
    logic [DATA_W-1:0]     mem_resp_data;

    // Arbiter side.
    modport slave (
        input  ic_req_valid, ic_req_addr,
        output ic_req_ready, ic_resp_valid, ic_resp_data,
        input  dc_req_valid, dc_req_rw, dc_req_addr, dc_req_data, dc_req_mask,
        output dc_req_ready, dc_resp_valid, dc_resp_data, dc_wr_ack,
        output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_tag,
        output mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
        input  mem_req_ready, mem_req_data_ready,
        input  mem_resp_valid, mem_resp_tag, mem_resp_data
    );

    // Environment side (caches + memory).
    modport master (
        output ic_req_valid, ic_req_addr,
        input  ic_req_ready, ic_resp_valid, ic_resp_data,
        output dc_req_valid, dc_req_rw, dc_req_addr, dc_req_data, dc_req_mask,
        input  dc_req_ready, dc_resp_valid, dc_resp_data, dc_wr_ack,
        input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_tag,
        input  mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
        output mem_req_ready, mem_req_data_ready,
        output mem_resp_valid, mem_resp_tag, mem_resp_data
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin share of one tagged memory port between icache refill and dcache refill/writeback.
// Latency: read = accept + 1 CMD cycle (min) + BEATS beats; beats forwarded combinationally.
// Backpressure: one transaction in flight; req ready only in IDLE; CMD/WDATA hold until memory ready.
// Ports: clk, reset (async, active low), bus (mem_arbiter_if.slave), busy (not IDLE),
// tag_err (sticky: wrong-tag beat or beat outside RESP).
module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128,
    parameter int TAG_W  = 4,
    parameter int BEATS  = 4
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus,
    output logic          busy,
    output logic          tag_err
);
    localparam int MASK_W = DATA_W / 8;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CMD   = 2'd1;
    localparam logic [1:0] S_WDATA = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic OWN_IC = 1'b0;
    localparam logic OWN_DC = 1'b1;

    logic [1:0]        state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              owner_q, owner_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [MASK_W-1:0] mask_q, mask_d;
    logic [TAG_W-1:0]  cur_tag_q, cur_tag_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              tag_err_q, tag_err_d;

    logic idle;
    logic grant_ic;
    logic grant_dc;
    logic beat_hit;
    logic beat_last;

    assign idle = (state_q == S_IDLE);

    // dcache wins a tie unless it was the last one served.
    assign grant_dc = idle && bus.dc_req_valid && (!bus.ic_req_valid || (last_grant_q == OWN_IC));
    assign grant_ic = idle && bus.ic_req_valid && !grant_dc;

    assign beat_hit  = (state_q == S_RESP) && bus.mem_resp_valid && (bus.mem_resp_tag == cur_tag_q);
    assign beat_last = (beat_q == BEAT_W'(BEATS - 1));

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        rw_d         = rw_q;
        addr_d       = addr_q;
        data_d       = data_q;
        mask_d       = mask_q;
        cur_tag_d    = cur_tag_q;
        beat_d       = beat_q;
        // Any beat not consumed as a hit is a stray: wrong tag or wrong state.
        tag_err_d    = tag_err_q | (bus.mem_resp_valid & ~beat_hit);

        case (state_q)
            S_IDLE: begin
                if (grant_dc) begin
                    addr_d       = bus.dc_req_addr;
                    rw_d         = bus.dc_req_rw;
                    data_d       = bus.dc_req_data;
                    mask_d       = bus.dc_req_mask;
                    owner_d      = OWN_DC;
                    last_grant_d = OWN_DC;
                    state_d      = S_CMD;
                end else if (grant_ic) begin
                    addr_d       = bus.ic_req_addr;
                    rw_d         = 1'b0;
                    data_d       = '0;
                    mask_d       = '0;
                    owner_d      = OWN_IC;
                    last_grant_d = OWN_IC;
                    state_d      = S_CMD;
                end
            end
            S_CMD: begin
                if (bus.mem_req_ready) begin
                    if (rw_q) begin
                        state_d = S_WDATA;
                    end else begin
                        state_d = S_RESP;
                        beat_d  = '0;
                    end
                end
            end
            S_WDATA: begin
                if (bus.mem_req_data_ready) begin
                    cur_tag_d = cur_tag_q + TAG_W'(1);
                    state_d   = S_IDLE;
                end
            end
            S_RESP: begin
                if (beat_hit) begin
                    if (beat_last) begin
                        beat_d    = '0;
                        cur_tag_d = cur_tag_q + TAG_W'(1);
                        state_d   = S_IDLE;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= OWN_IC;
            owner_q      <= OWN_IC;
            rw_q         <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            mask_q       <= '0;
            cur_tag_q    <= '0;
            beat_q       <= '0;
            tag_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            rw_q         <= rw_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            mask_q       <= mask_d;
            cur_tag_q    <= cur_tag_d;
            beat_q       <= beat_d;
            tag_err_q    <= tag_err_d;
        end
    end

    assign bus.ic_req_ready = grant_ic;
    assign bus.dc_req_ready = grant_dc;

    assign bus.mem_req_valid = (state_q == S_CMD);
    assign bus.mem_req_rw    = rw_q;
    assign bus.mem_req_addr  = addr_q;
    assign bus.mem_req_tag   = cur_tag_q;

    assign bus.mem_req_data_valid = (state_q == S_WDATA);
    assign bus.mem_req_data_bits  = data_q;
    assign bus.mem_req_data_mask  = mask_q;
    assign bus.dc_wr_ack          = (state_q == S_WDATA) && bus.mem_req_data_ready;

    // Data is gated so an idle response port reads as zero.
    assign bus.ic_resp_valid = beat_hit && (owner_q == OWN_IC);
    assign bus.dc_resp_valid = beat_hit && (owner_q == OWN_DC);
    assign bus.ic_resp_data  = bus.ic_resp_valid ? bus.mem_resp_data : '0;
    assign bus.dc_resp_data  = bus.dc_resp_valid ? bus.mem_resp_data : '0;

    assign busy    = !idle;
    assign tag_err = tag_err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    logic clk;
    logic reset;
    logic busy;
    logic tag_err;

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .busy    (busy),
        .tag_err (tag_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic         owner;   // 0 = icache, 1 = dcache
        logic [127:0] data;
    } beat_t;

    beat_t sb[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] mk(input int s, input int i);
        mk = {4{32'(s * 256 + i)}};
    endfunction

    function automatic logic [9:0] outs();
        outs = {bus.ic_req_ready, bus.ic_resp_valid, bus.dc_req_ready, bus.dc_resp_valid,
                bus.dc_wr_ack, bus.mem_req_valid, bus.mem_req_data_valid, busy, tag_err,
                (bus.ic_resp_data != '0) || (bus.dc_resp_data != '0)};
    endfunction

    // Drive one memory beat; a beat expected to reach a cache is queued first.
    task automatic mem_beat(input logic [3:0] tag, input logic [127:0] data,
                            input bit match, input bit owner);
        beat_t e;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_tag   = tag;
        bus.mem_resp_data  = data;
        if (match) begin
            e.owner = owner;
            e.data  = data;
            sb.push_back(e);
        end
        #1;
        chk1("ic_resp_valid", bus.ic_resp_valid, match && !owner);
        chk1("dc_resp_valid", bus.dc_resp_valid, match && owner);
        if (bus.ic_resp_valid || bus.dc_resp_valid) begin
            chk1("sb_pending", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk1("resp_owner", bus.dc_resp_valid, e.owner);
                chk("resp_data", e.owner ? bus.dc_resp_data : bus.ic_resp_data, e.data);
            end
        end
        cyc();
        bus.mem_resp_valid = 1'b0;
    endtask

    task automatic cmd_phase(input logic rw, input logic [27:0] addr,
                             input logic [3:0] tag, input int stall);
        for (int i = 0; i <= stall; i++) begin
            if (i == stall) bus.mem_req_ready = 1'b1;
            #1;
            chk1("cmd_valid", bus.mem_req_valid, 1'b1);
            chk1("cmd_rw", bus.mem_req_rw, rw);
            chk("cmd_addr", 128'(bus.mem_req_addr), 128'(addr));
            chk("cmd_tag", 128'(bus.mem_req_tag), 128'(tag));
            chk1("cmd_ic_rdy", bus.ic_req_ready, 1'b0);
            chk1("cmd_dc_rdy", bus.dc_req_ready, 1'b0);
            cyc();
        end
        bus.mem_req_ready = 1'b0;
    endtask

    task automatic read_beats(input bit owner, input logic [3:0] tag, input int seed);
        for (int i = 0; i < 4; i++) begin
            mem_beat(tag, mk(seed, i), 1'b1, owner);
            #1;
            chk1("busy_during_read", busy, i < 3);
        end
    endtask

    task automatic req_ic(input logic [27:0] addr);
        bus.ic_req_valid = 1'b1;
        bus.ic_req_addr  = addr;
        #1;
        chk1("ic_grant_rdy", bus.ic_req_ready, 1'b1);
        chk1("ic_grant_dc_rdy", bus.dc_req_ready, 1'b0);
        cyc();
        bus.ic_req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        bus.ic_req_valid = 1'b0; bus.ic_req_addr = '0;
        bus.dc_req_valid = 1'b0; bus.dc_req_rw = 1'b0; bus.dc_req_addr = '0;
        bus.dc_req_data = '0; bus.dc_req_mask = '0;
        bus.mem_req_ready = 1'b0; bus.mem_req_data_ready = 1'b0;
        bus.mem_resp_valid = 1'b0; bus.mem_resp_tag = '0; bus.mem_resp_data = '0;

        // Reset and quiet idle period.
        repeat (3) cyc();
        chk("reset_outs", 128'(outs()), 128'(0));
        chk("reset_addr", 128'(bus.mem_req_addr), 128'(0));
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("idle_outs", 128'(outs()), 128'(0));
        end

        // icache read, tag 0.
        req_ic(28'h0000100);
        cmd_phase(1'b0, 28'h0000100, 4'd0, 0);
        read_beats(1'b0, 4'd0, 1);
        chk1("rd_tag_err", tag_err, 1'b0);

        // dcache write, tag 1, write-data ready held low 3 cycles.
        bus.dc_req_valid = 1'b1; bus.dc_req_rw = 1'b1; bus.dc_req_addr = 28'h0000200;
        bus.dc_req_data = mk(9, 0); bus.dc_req_mask = 16'hFFFF;
        #1;
        chk1("wr_dc_rdy", bus.dc_req_ready, 1'b1);
        chk1("wr_ic_rdy", bus.ic_req_ready, 1'b0);
        cyc();
        bus.dc_req_valid = 1'b0; bus.dc_req_data = '0; bus.dc_req_mask = '0;
        cmd_phase(1'b1, 28'h0000200, 4'd1, 2);
        for (int i = 0; i < 3; i++) begin
            chk1("wd_valid", bus.mem_req_data_valid, 1'b1);
            chk("wd_bits", bus.mem_req_data_bits, mk(9, 0));
            chk("wd_mask", 128'(bus.mem_req_data_mask), 128'(16'hFFFF));
            chk1("wd_no_ack", bus.dc_wr_ack, 1'b0);
            cyc();
        end
        bus.mem_req_data_ready = 1'b1;
        #1;
        chk1("wr_ack", bus.dc_wr_ack, 1'b1);
        chk1("wr_busy", busy, 1'b1);
        cyc();
        bus.mem_req_data_ready = 1'b0;
        #1;
        chk1("wr_ack_gone", bus.dc_wr_ack, 1'b0);
        chk1("wr_busy_gone", busy, 1'b0);

        // icache read tag 2 with a wrong-tag beat after the first beat.
        req_ic(28'h0000300);
        cmd_phase(1'b0, 28'h0000300, 4'd2, 0);
        mem_beat(4'd2, mk(3, 0), 1'b1, 1'b0);
        mem_beat(4'd5, mk(3, 99), 1'b0, 1'b0);
        #1;
        chk1("bad_tag_err", tag_err, 1'b1);
        for (int i = 1; i < 4; i++) begin
            mem_beat(4'd2, mk(3, i), 1'b1, 1'b0);
            #1;
            chk1("bad_tag_busy", busy, i < 3);
        end
        chk1("bad_tag_sticky", tag_err, 1'b1);

        // Reset pulsed in the middle of a read (tag 3) after two beats.
        req_ic(28'h0000400);
        cmd_phase(1'b0, 28'h0000400, 4'd3, 0);
        mem_beat(4'd3, mk(4, 0), 1'b1, 1'b0);
        mem_beat(4'd3, mk(4, 1), 1'b1, 1'b0);
        reset = 1'b0;
        #1;
        chk("midrst_outs", 128'(outs()), 128'(0));
        cyc();
        reset = 1'b1;

        // Both requesters held from reset: dc, then ic, then dc.
        bus.ic_req_valid = 1'b1; bus.ic_req_addr = 28'h0000600;
        bus.dc_req_valid = 1'b1; bus.dc_req_rw = 1'b0; bus.dc_req_addr = 28'h0000500;
        #1;
        chk1("rr1_dc_rdy", bus.dc_req_ready, 1'b1);
        chk1("rr1_ic_rdy", bus.ic_req_ready, 1'b0);
        cyc();
        cmd_phase(1'b0, 28'h0000500, 4'd0, 0);
        read_beats(1'b1, 4'd0, 5);
        chk1("rr2_ic_rdy", bus.ic_req_ready, 1'b1);
        chk1("rr2_dc_rdy", bus.dc_req_ready, 1'b0);
        cyc();
        cmd_phase(1'b0, 28'h0000600, 4'd1, 0);
        read_beats(1'b0, 4'd1, 6);
        chk1("rr3_dc_rdy", bus.dc_req_ready, 1'b1);
        chk1("rr3_ic_rdy", bus.ic_req_ready, 1'b0);
        cyc();
        bus.ic_req_valid = 1'b0; bus.dc_req_valid = 1'b0;
        cmd_phase(1'b0, 28'h0000500, 4'd2, 0);
        read_beats(1'b1, 4'd2, 7);
        chk1("rr_tag_err", tag_err, 1'b0);

        // A beat while IDLE is dropped even with the current tag, and flags tag_err.
        mem_beat(4'd3, mk(8, 0), 1'b0, 1'b0);
        #1;
        chk1("idle_beat_err", tag_err, 1'b1);
        chk1("sb_drained", sb.size() == 0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
